ldtbl_loader: RTL and testbench

Sequencing controller for the load-table/map resource (16 entries, each a 48-bit load-table word plus a 12-bit map). It bulk-loads a contiguous range of entries from a valid/ready configuration stream and optionally reads each entry back to verify it. It shares the table's external access port with a host. The host is passed through while the loader is idle and stalled while a load runs.

---
 rtl/ldtbl_loader.sv | 154 +++++++++++++++
 tb/tb_ldtbl_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ldtbl_loader.sv
// ldtbl_loader: bulk loader for the 16-entry load-table/map resource.
// Streams hi/lo/map words for a contiguous (wrapping) range of entries into
// the shared table port, optionally reads each entry back to verify it, and
// passes the host through to the table only while idle.
module ldtbl_loader #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_verify,
  input  logic [3:0]        i_first,
  input  logic [3:0]        i_last,
  input  logic              i_sd_valid,
  input  logic [DATA_W-1:0] i_sd,
  output logic              o_sd_ready,
  input  logic              i_hwe,
  input  logic              i_hre,
  input  logic [5:0]        i_ha,
  input  logic [DATA_W-1:0] i_hwd,
  output logic [DATA_W-1:0] o_hrd,
  output logic              o_hbusy,
  output logic              o_exwe,
  output logic              o_exre,
  output logic [5:0]        o_exa,
  output logic [DATA_W-1:0] o_exwd,
  input  logic [DATA_W-1:0] i_exrd,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [3:0]        o_err_ent
);

  typedef enum logic [2:0] {IDLE, WHI, WLO, WMAP, RLO, RMAP, DONE} state_t;

  state_t            state;
  logic [3:0]        ent;
  logic [3:0]        last;
  logic              vfy;
  logic [DATA_W-1:0] lo_q;
  logic [11:0]       map_q;
  logic              mis;

  assign o_busy  = (state != IDLE);
  assign o_hbusy = (state != IDLE);
  assign o_hrd   = i_exrd;

  // Readback compare, same cycle as the table read
  always_comb begin
    mis = 1'b0;
    if (state == RLO)
      mis = (i_exrd != lo_q);
    else if (state == RMAP)
      mis = (i_exrd != {{(DATA_W-12){1'b0}}, map_q});
  end

  // Table port mux: host pass-through in IDLE, stream writes / readback otherwise
  always_comb begin
    o_exwe     = 1'b0;
    o_exre     = 1'b0;
    o_exa      = '0;
    o_exwd     = '0;
    o_sd_ready = 1'b0;
    case (state)
      IDLE: begin
        o_exwe = i_hwe;
        o_exre = i_hre;
        o_exa  = i_ha;
        o_exwd = i_hwd;
      end
      WHI, WLO, WMAP: begin
        o_sd_ready = 1'b1;
        o_exwe     = i_sd_valid;
        o_exwd     = i_sd;
        o_exa      = (state == WHI) ? {ent, 2'b10} :
                     (state == WLO) ? {ent, 2'b01} : {ent, 2'b11};
      end
      RLO: begin
        o_exre = 1'b1;
        o_exa  = {ent, 2'b00};
      end
      RMAP: begin
        o_exre = 1'b1;
        o_exa  = {ent, 2'b11};
      end
      default: ;
    endcase
  end

  // Sequencer: entry walk, shadow copies, done pulse and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ent       <= '0;
      last      <= '0;
      vfy       <= 1'b0;
      lo_q      <= '0;
      map_q     <= '0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_err_ent <= '0;
    end else begin
      o_done <= 1'b0;
      if (mis) begin
        if (!o_err) o_err_ent <= ent;
        o_err <= 1'b1;
      end
      if (state != IDLE && i_abort) begin
        // the word accepted this cycle has already gone out combinationally
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (i_start) begin
            state     <= WHI;
            ent       <= i_first;
            last      <= i_last;
            vfy       <= i_verify;
            o_err     <= 1'b0;
            o_err_ent <= '0;
          end
          WHI: if (i_sd_valid) state <= WLO;
          WLO: if (i_sd_valid) begin
            lo_q  <= i_sd;
            state <= WMAP;
          end
          WMAP: if (i_sd_valid) begin
            map_q <= i_sd[11:0];
            if (vfy) begin
              state <= RLO;
            end else if (ent == last) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              ent   <= ent + 4'd1;
              state <= WHI;
            end
          end
          RLO: state <= RMAP;
          RMAP: if (ent == last) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            ent   <= ent + 4'd1;
            state <= WHI;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ldtbl_loader.sv
// Directed bench for ldtbl_loader with a small behavioural table model
// (write fields 10=hi, 01=lo, 11=map; read fields 00/01=lo, 10=hi, 11=map).
module tb_ldtbl_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort, i_verify;
  logic [3:0]  i_first, i_last;
  logic        i_sd_valid;
  logic [23:0] i_sd;
  logic        o_sd_ready;
  logic        i_hwe, i_hre;
  logic [5:0]  i_ha;
  logic [23:0] i_hwd, o_hrd;
  logic        o_hbusy, o_exwe, o_exre;
  logic [5:0]  o_exa;
  logic [23:0] o_exwd, i_exrd;
  logic        o_busy, o_done, o_err;
  logic [3:0]  o_err_ent;

  int checks = 0;
  int errors = 0;
  int wcnt = 0;
  int wb;
  logic corrupt = 1'b0;

  logic [23:0] hi_m [16];
  logic [23:0] lo_m [16];
  logic [11:0] map_m [16];

  always #5 clk = ~clk;

  ldtbl_loader #(.DATA_W(24)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_verify(i_verify),
    .i_first(i_first), .i_last(i_last), .i_sd_valid(i_sd_valid), .i_sd(i_sd),
    .o_sd_ready(o_sd_ready), .i_hwe(i_hwe), .i_hre(i_hre), .i_ha(i_ha), .i_hwd(i_hwd),
    .o_hrd(o_hrd), .o_hbusy(o_hbusy), .o_exwe(o_exwe), .o_exre(o_exre), .o_exa(o_exa),
    .o_exwd(o_exwd), .i_exrd(i_exrd), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_err_ent(o_err_ent)
  );

  // table model: registered write, combinational read, optional corrupted lo of entry 5
  always @(posedge clk) begin
    if (o_exwe) begin
      case (o_exa[1:0])
        2'b10: hi_m[o_exa[5:2]] <= o_exwd;
        2'b01: lo_m[o_exa[5:2]] <= o_exwd;
        2'b11: map_m[o_exa[5:2]] <= o_exwd[11:0];
        default: ;
      endcase
      wcnt <= wcnt + 1;
    end
  end

  always_comb begin
    case (o_exa[1:0])
      2'b10:   i_exrd = hi_m[o_exa[5:2]];
      2'b11:   i_exrd = {12'h000, map_m[o_exa[5:2]]};
      default: i_exrd = lo_m[o_exa[5:2]];
    endcase
    if (corrupt && o_exre && o_exa == 6'h14) i_exrd = 24'h123457;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ents [4];
    int e;
    ents = '{14, 15, 0, 1};
    rst = 1'b1; i_start = 0; i_abort = 0; i_verify = 0; i_first = 0; i_last = 0;
    i_sd_valid = 0; i_sd = 0; i_hre = 0; i_hwd = 24'h111111;
    i_hwe = 1; i_ha = 6'h15;
    for (int k = 0; k < 16; k++) begin hi_m[k] = 0; lo_m[k] = 0; map_m[k] = 0; end
    #2;
    // reset values and IDLE pass-through
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_err_ent", o_err_ent, 0);
    chk("rst_sd_ready", o_sd_ready, 0);
    chk("rst_hbusy", o_hbusy, 0);
    chk("rst_pass_we", o_exwe, 1);
    chk("rst_pass_a", o_exa, 6'h15);
    chk("rst_pass_wd", o_exwd, 24'h111111);
    i_hwe = 0;
    tick; rst = 1'b0;
    tick;

    // full range, no verify
    i_first = 0; i_last = 15; i_verify = 0; i_start = 1;
    tick; i_start = 0; wb = wcnt;
    for (int k = 0; k < 48; k++) begin
      i_sd_valid = 1;
      i_sd = (k % 3 == 0) ? 24'hA00000 + 24'(k / 3) :
             (k % 3 == 1) ? 24'hB00000 + 24'(k / 3) : 24'h000C00 + 24'(k / 3);
      if (k == 0) begin #2; chk("t1_busy", o_busy, 1); chk("t1_hbusy", o_hbusy, 1); end
      tick;
    end
    i_sd_valid = 0;
    #2; chk("t1_done", o_done, 1); chk("t1_wcnt", 32'(wcnt - wb), 48);
    tick; chk("t1_idle", o_busy, 0); chk("t1_done_clr", o_done, 0);
    i_hre = 1;
    for (int k = 0; k < 16; k++) begin
      i_ha = 6'(k * 4); #1; chk("t1_readback", o_hrd, 24'hB00000 + 24'(k));
    end
    i_hre = 0;
    tick;

    // single entry with verify, all matching
    i_first = 3; i_last = 3; i_verify = 1; i_start = 1;
    tick; i_start = 0; i_sd_valid = 1; i_sd = 24'hABCDEF;
    tick; i_sd = 24'h123456;
    tick; i_sd = 24'h000FED;
    tick; i_sd_valid = 0;
    #2; chk("t2_rlo_re", o_exre, 1); chk("t2_rlo_a", o_exa, 6'h0C);
    tick; #2; chk("t2_rmap_re", o_exre, 1); chk("t2_rmap_a", o_exa, 6'h0F);
    tick; #2; chk("t2_done", o_done, 1); chk("t2_err", o_err, 0);
    tick;

    // verify with a corrupted readback on entry 5 of 4..6
    corrupt = 1;
    i_first = 4; i_last = 6; i_verify = 1; i_start = 1;
    tick; i_start = 0;
    for (int c = 0; c < 15; c++) begin
      e = 4 + c / 5;
      i_sd_valid = (c % 5) < 3;
      i_sd = (c % 5 == 0) ? 24'h200000 + 24'(e) :
             (c % 5 == 1) ? 24'h300000 + 24'(e) : 24'h000400 + 24'(e);
      tick;
    end
    i_sd_valid = 0;
    #2; chk("t3_done", o_done, 1); chk("t3_err", o_err, 1); chk("t3_err_ent", o_err_ent, 5);
    tick; corrupt = 0;
    i_hre = 1; i_ha = 6'h18; #1; chk("t3_ent6_lo", o_hrd, 24'h300006); i_hre = 0;
    tick;

    // wrapping range, stalled stream, held host write
    i_first = 14; i_last = 1; i_verify = 0; i_start = 1;
    tick; i_start = 0;
    chk("t4_err_clr", o_err, 0); chk("t4_err_ent_clr", o_err_ent, 0);
    for (int i = 0; i < 4; i++) begin
      e = ents[i];
      for (int f = 0; f < 3; f++) begin
        if (i == 0 && f == 1) begin
          repeat (2) begin
            i_sd_valid = 0; i_sd = 24'hDEAD00;
            i_hwe = 1; i_ha = 6'h3E; i_hwd = 24'h5A5A5A;
            #2; chk("t4_stall_we", o_exwe, 0); chk("t4_hbusy", o_hbusy, 1);
            tick;
          end
        end
        i_sd_valid = 1;
        i_sd = (f == 0) ? 24'h400000 + 24'(e) :
               (f == 1) ? 24'h500000 + 24'(e) : 24'h000600 + 24'(e);
        #2; chk("t4_ent", o_exa[5:2], e);
        tick;
      end
    end
    i_sd_valid = 0;
    #2; chk("t4_done", o_done, 1); chk("t4_host_blocked", o_exwe, 0);
    tick;
    #2; chk("t4_hbusy_clr", o_hbusy, 0); chk("t4_host_we", o_exwe, 1); chk("t4_host_a", o_exa, 6'h3E);
    tick; i_hwe = 0; i_hre = 1;
    i_ha = 6'h3E; #1; chk("t4_host_data", o_hrd, 24'h5A5A5A);
    i_ha = 6'h00; #1; chk("t4_ent0_lo", o_hrd, 24'h500000);
    i_ha = 6'h3C; #1; chk("t4_ent15_lo", o_hrd, 24'h50000F);
    i_hre = 0;
    tick;

    // abort in WMAP: word still written, no done
    i_first = 2; i_last = 3; i_verify = 0; i_start = 1;
    tick; i_start = 0; i_sd_valid = 1; i_sd = 24'h111111;
    tick; i_sd = 24'h222222;
    tick; i_sd = 24'h000777; i_abort = 1;
    #2; chk("t5_abort_we", o_exwe, 1);
    tick; i_abort = 0; i_sd_valid = 0;
    chk("t5_idle", o_busy, 0); chk("t5_no_done", o_done, 0);
    tick; chk("t5_no_done2", o_done, 0);
    i_hre = 1; i_ha = 6'h0B; #1; chk("t5_map", o_hrd, 24'h000777); i_hre = 0;
    tick;

    // asynchronous reset during RLO
    i_first = 1; i_last = 1; i_verify = 1; i_start = 1;
    tick; i_start = 0; i_sd_valid = 1; i_sd = 24'h010101;
    tick; i_sd = 24'h020202;
    tick; i_sd = 24'h000303;
    tick; i_sd_valid = 0;
    #2; chk("t6_rlo_re", o_exre, 1); chk("t6_rlo_a", o_exa, 6'h04);
    rst = 1; i_hre = 1; i_ha = 6'h05;
    #1;
    chk("t6_busy", o_busy, 0); chk("t6_sd_ready", o_sd_ready, 0); chk("t6_hbusy", o_hbusy, 0);
    chk("t6_pass_re", o_exre, 1); chk("t6_pass_a", o_exa, 6'h05); chk("t6_err", o_err, 0);
    tick; rst = 0; i_hre = 0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
